// File: rtl/mat_op_sequencer.sv
// Operand sequencer / result collector driving a 3x3 MAC-array multiplier (clear, 3 load cycles, 9 unloads).
// Latency: start to done is 15 cycles; rd_data follows rd_addr by 1 cycle. No backpressure: start is ignored while a run is active.
// Optional MATSEQ_CLR_BUF_EN: zero the result buffer at the end of the CLEAR cycle.
module mat_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_w1,
    output logic [DATA_W-1:0] data_w2,
    output logic [DATA_W-1:0] data_w3,
    output logic [DATA_W-1:0] data_x1,
    output logic [DATA_W-1:0] data_x2,
    output logic [DATA_W-1:0] data_x3,
    output logic              clear,
    output logic              load,
    output logic              unload_res,
    input  logic [RES_W-1:0]  res_in,
    input  logic [3:0]        rd_addr,
    output logic [RES_W-1:0]  rd_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_UNLOAD, S_TAIL, S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] w_mem [9];
    logic [DATA_W-1:0] x_mem [9];
    logic [RES_W-1:0]  c_mem [9];
    logic              cap_vld;
    logic [3:0]        cap_idx;

    logic              busy_nxt, done_nxt, clear_nxt, load_nxt, unload_nxt;
    logic [DATA_W-1:0] w_op_nxt [3];
    logic [DATA_W-1:0] x_op_nxt [3];
    logic [3:0]        k_idx, x_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                state_nxt = S_LOAD;
                cnt_nxt   = '0;
            end
            S_LOAD: begin
                if (cnt == 4'd2) begin
                    state_nxt = S_UNLOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_UNLOAD: begin
                if (cnt == 4'd8) begin
                    state_nxt = S_TAIL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_TAIL:   state_nxt = S_FIN;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without extra latency.
    always_comb begin
        busy_nxt   = (state_nxt == S_CLEAR) || (state_nxt == S_LOAD) ||
                     (state_nxt == S_UNLOAD) || (state_nxt == S_TAIL);
        done_nxt   = (state_nxt == S_FIN);
        clear_nxt  = (state_nxt == S_CLEAR);
        load_nxt   = (state_nxt == S_LOAD);
        unload_nxt = (state_nxt == S_UNLOAD);
        k_idx      = {2'b00, cnt_nxt[1:0]};
        x_base     = k_idx * 4'd3;
        for (int i = 0; i < 3; i++) begin
            w_op_nxt[i] = '0;
            x_op_nxt[i] = '0;
        end
        if (load_nxt) begin
            w_op_nxt[0] = w_mem[k_idx];
            w_op_nxt[1] = w_mem[k_idx + 4'd3];
            w_op_nxt[2] = w_mem[k_idx + 4'd6];
            x_op_nxt[0] = x_mem[x_base];
            x_op_nxt[1] = x_mem[x_base + 4'd1];
            x_op_nxt[2] = x_mem[x_base + 4'd2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            clear      <= 1'b0;
            load       <= 1'b0;
            unload_res <= 1'b0;
            data_w1    <= '0;
            data_w2    <= '0;
            data_w3    <= '0;
            data_x1    <= '0;
            data_x2    <= '0;
            data_x3    <= '0;
        end else begin
            busy       <= busy_nxt;
            done       <= done_nxt;
            clear      <= clear_nxt;
            load       <= load_nxt;
            unload_res <= unload_nxt;
            data_w1    <= w_op_nxt[0];
            data_w2    <= w_op_nxt[1];
            data_w3    <= w_op_nxt[2];
            data_x1    <= x_op_nxt[0];
            data_x2    <= x_op_nxt[1];
            data_x3    <= x_op_nxt[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                w_mem[i] <= '0;
                x_mem[i] <= '0;
            end
        end else if (wr_en && (state == S_IDLE) && (wr_addr <= 4'd8)) begin
            if (wr_sel) x_mem[wr_addr] <= wr_data;
            else        w_mem[wr_addr] <= wr_data;
        end
    end

    // The multiplier presents each result one cycle after its unload strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld <= 1'b0;
            cap_idx <= '0;
            for (int i = 0; i < 9; i++) c_mem[i] <= '0;
        end else begin
            cap_vld <= unload_res;
            if (state == S_CLEAR)  cap_idx <= '0;
            else if (cap_vld)      cap_idx <= cap_idx + 4'd1;
`ifdef MATSEQ_CLR_BUF_EN
            if (state == S_CLEAR) begin
                for (int i = 0; i < 9; i++) c_mem[i] <= '0;
            end
`endif
            if (cap_vld && (cap_idx <= 4'd8)) c_mem[cap_idx] <= res_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rd_data <= '0;
        else if (rd_addr <= 4'd8)  rd_data <= c_mem[rd_addr];
        else                       rd_data <= '0;
    end

endmodule

// File: tb/tb_mat_op_sequencer.sv
// Directed bench for mat_op_sequencer with a behavioural 3x3 MAC-array responder.
module tb_mat_op_sequencer;
    localparam int DATA_W = 4;
    localparam int RES_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [3:0]        wr_addr = '0, rd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              busy, done, clear, load, unload_res;
    logic [DATA_W-1:0] data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;
    logic [RES_W-1:0]  res_in, rd_data;

    always #5 clk = ~clk;

    mat_op_sequencer #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .data_w1(data_w1), .data_w2(data_w2), .data_w3(data_w3),
        .data_x1(data_x1), .data_x2(data_x2), .data_x3(data_x3),
        .clear(clear), .load(load), .unload_res(unload_res),
        .res_in(res_in), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Responder: accumulate on load, shift results out one cycle after each unload strobe.
    int acc [9];
    int ucnt;
    int wv [3];
    int xv [3];
    always_comb begin
        wv[0] = int'(data_w1); wv[1] = int'(data_w2); wv[2] = int'(data_w3);
        xv[0] = int'(data_x1); xv[1] = int'(data_x2); xv[2] = int'(data_x3);
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) acc[i] <= 0;
            ucnt   <= 0;
            res_in <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < 9; i++) acc[i] <= 0;
                ucnt <= 0;
            end else if (load) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        acc[r*3+c] <= acc[r*3+c] + wv[r] * xv[c];
            end
            if (unload_res && ucnt < 9) begin
                res_in <= RES_W'(acc[ucnt]);
                ucnt   <= ucnt + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int addr, input int val);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = DATA_W'(val);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int addr, input int exp);
        rd_addr = 4'(addr);
        tick();
        chk($sformatf("%s[%0d]", tag, addr), 32'(rd_data), 32'(exp));
    endtask

    // Expected operand vectors for W=identity, X=1..9, cycles 2..4 ({o1,o2,o3} nibbles).
    logic [11:0] exp_w [3] = '{12'h100, 12'h010, 12'h001};
    logic [11:0] exp_x [3] = '{12'h123, 12'h456, 12'h789};

    // Caller is in cycle 0 (#1 after an edge); cycles 1..16 are checked here.
    task automatic run(input string tag, input bit ops, input bit disturb,
                       input bit watch, input int abort_at);
        int w4;
        start = 1'b1;
        if (watch) rd_addr = 4'd4;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = disturb && (c == 3 || c == 10);
            if (disturb && c == 6) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 4'd7;
            end else begin
                wr_en = 1'b0;
            end
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " rst busy"},   32'(busy), 0);
                chk({tag, " rst done"},   32'(done), 0);
                chk({tag, " rst ctl"},    32'({clear, load, unload_res}), 0);
                chk({tag, " rst ops"},    32'({data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
                chk({tag, " rst rddat"},  32'(rd_data), 0);
                start = 1'b0;
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            chk($sformatf("%s clear c%0d", tag, c),  32'(clear),      32'(c == 1));
            chk($sformatf("%s load c%0d", tag, c),   32'(load),       32'(c >= 2 && c <= 4));
            chk($sformatf("%s unload c%0d", tag, c), 32'(unload_res), 32'(c >= 5 && c <= 13));
            chk($sformatf("%s busy c%0d", tag, c),   32'(busy),       32'(c >= 1 && c <= 14));
            chk($sformatf("%s done c%0d", tag, c),   32'(done),       32'(c == 15));
            if (ops && c >= 2 && c <= 4) begin
                chk($sformatf("%s w c%0d", tag, c), 32'({data_w1, data_w2, data_w3}), 32'(exp_w[c-2]));
                chk($sformatf("%s x c%0d", tag, c), 32'({data_x1, data_x2, data_x3}), 32'(exp_x[c-2]));
            end else if (!(c >= 2 && c <= 4)) begin
                chk($sformatf("%s ops0 c%0d", tag, c),
                    32'({data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
            end
            if (watch) begin
`ifdef MATSEQ_CLR_BUF_EN
                w4 = (c <= 2) ? 675 : 0;
`else
                w4 = (c <= 11) ? 675 : 0;
`endif
                chk($sformatf("%s c4 c%0d", tag, c), 32'(rd_data), 32'(w4));
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic load_identity();
        for (int i = 0; i < 9; i++) wr(1'b0, i, (i % 4 == 0) ? 1 : 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",  32'(busy), 0);
        chk("reset done",  32'(done), 0);
        chk("reset ctl",   32'({clear, load, unload_res}), 0);
        chk("reset ops",   32'({data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
        chk("reset rddat", 32'(rd_data), 0);
        rst_n = 1'b1;
        tick();
        rd_chk("reset c", 0, 0);

        load_identity();
        for (int i = 0; i < 9; i++) wr(1'b1, i, i + 1);
        run("id", 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) rd_chk("id c", i, i + 1);

        for (int a = 9; a <= 15; a++) begin
            wr(1'b0, a, 15);
            wr(1'b1, a, 15);
        end
        rd_chk("bound rd", 12, 0);
        rd_chk("bound rd", 15, 0);

        run("prot", 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 9; i++) rd_chk("prot c", i, i + 1);
        run("again", 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) rd_chk("again c", i, i + 1);

        for (int i = 0; i < 9; i++) begin
            wr(1'b0, i, 15);
            wr(1'b1, i, 15);
        end
        run("max", 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) rd_chk("max c", i, 675);

        for (int i = 0; i < 9; i++) wr(1'b0, i, 0);
        run("clrbuf", 1'b0, 1'b0, 1'b1, 0);
        rd_chk("clrbuf c", 4, 0);

        load_identity();
        run("abort", 1'b0, 1'b0, 1'b0, 7);
        rd_chk("abort c", 0, 0);
        rd_chk("abort c", 8, 0);
        load_identity();
        for (int i = 0; i < 9; i++) wr(1'b1, i, i + 1);
        run("post", 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 9; i++) rd_chk("post c", i, i + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
